// File: rtl/kyber_pkg.sv
// Shared constants, loader state encoding and helpers for the Kyber coefficient loader.
// Optional KYBER_LOADER_MODRED_EN build uses cond_sub_q in the write path.
package kyber_pkg;

    localparam logic [11:0] KYBER_Q = 12'd3329;
    localparam int unsigned KYBER_N = 256;
    localparam int unsigned COEF_W  = 12;
    localparam int unsigned ADDR_W  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        LOADP = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } loader_state_e;

    // Core BRAM fill order: INTT input swaps the two low index bits.
    function automatic logic [ADDR_W-1:0] drain_addr(input logic [ADDR_W-1:0] r, input logic inv);
        return inv ? {r[7:2], r[0], r[1]} : r;
    endfunction

    // Single conditional subtraction of q; maps [0,4095] into [0,3328] for 12-bit inputs.
    function automatic logic [COEF_W-1:0] cond_sub_q(input logic [COEF_W-1:0] x);
        return (x >= KYBER_Q) ? COEF_W'(x - KYBER_Q) : x;
    endfunction

    // Load pulse vector ordered {a_f, a_i, b_f, b_i}.
    function automatic logic [3:0] load_sel(input logic sel_b, input logic inv);
        logic [3:0] v;
        v = 4'b0000;
        case ({sel_b, inv})
            2'b00:   v = 4'b1000;
            2'b01:   v = 4'b0100;
            2'b10:   v = 4'b0010;
            default: v = 4'b0001;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/kyber_coef_buf.sv
// 256x12 simple dual-port coefficient buffer: one write port, one synchronous read port.
// Read data is forced to zero when no read is issued so it can drive the core directly.
module kyber_coef_buf
    import kyber_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [COEF_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [COEF_W-1:0] rdata_o
);

    logic [COEF_W-1:0] mem_q [KYBER_N];
    logic [COEF_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/kyber_coef_loader.sv
// Buffers one 256-coefficient polynomial from a valid/ready stream and replays it to the
// KyberHPM1PE core as load pulse + 256 gap-free din words. Option: KYBER_LOADER_MODRED_EN.
module kyber_coef_loader
    import kyber_pkg::*;
#(
    parameter int unsigned PE_NUMBER = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          sel_b,
    input  logic                          inv,
    input  logic                          s_valid,
    input  logic [COEF_W-1:0]             s_data,
    output logic                          s_ready,
    output logic                          load_a_f,
    output logic                          load_a_i,
    output logic                          load_b_f,
    output logic                          load_b_i,
    output logic [COEF_W*PE_NUMBER-1:0]   din,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned DIN_W = COEF_W * PE_NUMBER;

    loader_state_e     state_q;
    logic              sel_b_q;
    logic              inv_q;
    logic [ADDR_W-1:0] wcnt_q;
    logic [ADDR_W-1:0] rcnt_q;
    logic              s_ready_q;
    logic [3:0]        load_q;
    logic              busy_q;
    logic              done_q;

    logic              wr_en;
    logic [COEF_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic [COEF_W-1:0] rd_data;

    assign wr_en = (state_q == FILL) && s_valid && s_ready_q;

`ifdef KYBER_LOADER_MODRED_EN
    assign wr_data = cond_sub_q(s_data);
`else
    assign wr_data = s_data;
`endif

    // Read one word ahead: LOADP fetches word 0, DRAIN cycle r fetches word r+1.
    always_comb begin
        rd_en  = 1'b0;
        rd_idx = '0;
        if (state_q == LOADP) begin
            rd_en = 1'b1;
        end else if ((state_q == DRAIN) && (rcnt_q != 8'd255)) begin
            rd_en  = 1'b1;
            rd_idx = ADDR_W'(rcnt_q + 8'd1);
        end
        rd_addr = drain_addr(rd_idx, inv_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_b_q   <= 1'b0;
            inv_q     <= 1'b0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            s_ready_q <= 1'b0;
            load_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            load_q <= '0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sel_b_q   <= sel_b;
                        inv_q     <= inv;
                        wcnt_q    <= '0;
                        rcnt_q    <= '0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    if (wr_en) begin
                        wcnt_q <= ADDR_W'(wcnt_q + 8'd1);
                        if (wcnt_q == 8'd255) begin
                            s_ready_q <= 1'b0;
                            load_q    <= load_sel(sel_b_q, inv_q);
                            state_q   <= LOADP;
                        end
                    end
                end
                LOADP: begin
                    rcnt_q  <= '0;
                    state_q <= DRAIN;
                end
                DRAIN: begin
                    if (rcnt_q == 8'd255) begin
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        rcnt_q <= ADDR_W'(rcnt_q + 8'd1);
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    s_ready_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    kyber_coef_buf u_buf (
        .clk_i   (clk),
        .reset_i (reset),
        .we_i    (wr_en),
        .waddr_i (wcnt_q),
        .wdata_i (wr_data),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign s_ready  = s_ready_q;
    assign load_a_f = load_q[3];
    assign load_a_i = load_q[2];
    assign load_b_f = load_q[1];
    assign load_b_i = load_q[0];
    assign din      = DIN_W'(rd_data);
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_kyber_coef_loader.sv
// Directed bench for kyber_coef_loader: table of load scenarios plus reset-abort sequences.
// Expected data honours KYBER_LOADER_MODRED_EN when the bench is built with it.
module tb_kyber_coef_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sel_b = 1'b0;
    logic        inv = 1'b0;
    logic        s_valid = 1'b0;
    logic [11:0] s_data = '0;
    logic        s_ready;
    logic        load_a_f, load_a_i, load_b_f, load_b_i;
    logic [11:0] din;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cnt_load [4];
    int cnt_done = 0;

    always #5 clk = ~clk;

    kyber_coef_loader #(.PE_NUMBER(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sel_b    (sel_b),
        .inv      (inv),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .load_a_f (load_a_f),
        .load_a_i (load_a_i),
        .load_b_f (load_b_f),
        .load_b_i (load_b_i),
        .din      (din),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        for (int k = 0; k < 4; k++) cnt_load[k] = 0;
    end

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        cnt_load[0] <= cnt_load[0] + int'(load_a_f);
        cnt_load[1] <= cnt_load[1] + int'(load_a_i);
        cnt_load[2] <= cnt_load[2] + int'(load_b_f);
        cnt_load[3] <= cnt_load[3] + int'(load_b_i);
        cnt_done    <= cnt_done + int'(done);
    end

    typedef struct {
        logic       sel_b;
        logic       inv;
        logic       toggle;
        int         pat;
        logic       start_mid;
        logic [3:0] exp_load;   // {a_f, a_i, b_f, b_i}
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int raw_data(input int pat, input int i);
        int v;
        case (pat)
            0: v = i;
            1: v = 255 - i;
            default: begin
                case (i)
                    0: v = 3328;
                    1: v = 3329;
                    2: v = 4095;
                    3: v = 0;
                    default: v = (i * 37 + 5) % 4096;
                endcase
            end
        endcase
        return v;
    endfunction

    function automatic int stored_data(input int pat, input int i);
        int v;
        v = raw_data(pat, i);
`ifdef KYBER_LOADER_MODRED_EN
        if (v >= 3329) v = v - 3329;
`endif
        return v;
    endfunction

    // Index of the word the core expects at drain position r.
    function automatic int exp_index(input logic inv_f, input int r);
        int ofs [4];
        ofs[0] = 0; ofs[1] = 2; ofs[2] = 1; ofs[3] = 3;
        if (!inv_f) return r;
        return (r / 4) * 4 + ofs[r % 4];
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_s_ready"}, int'(s_ready), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_din"}, int'(din), 0);
        chk({tag, "_loads"}, int'({load_a_f, load_a_i, load_b_f, load_b_i}), 0);
    endtask

    task automatic run_vec(input vec_t v, input int abort_fill, input int abort_drain);
        int  i;
        int  cyc;
        bit  ph;
        int  base_load [4];
        int  base_done;
        bit  aborted;
        int  exp_w;
        aborted = 1'b0;
        for (int k = 0; k < 4; k++) base_load[k] = cnt_load[k];
        base_done = cnt_done;

        @(negedge clk);
        start = 1'b1; sel_b = v.sel_b; inv = v.inv;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_ready", int'(s_ready), 1);
        // Opposite config stays on the pins to catch any re-latching.
        sel_b = ~v.sel_b; inv = ~v.inv;

        i = 0; cyc = 0; ph = 1'b1;
        s_valid = v.toggle ? ph : 1'b1;
        s_data  = 12'(raw_data(v.pat, 0));
        if (s_valid && s_ready) i++;
        while (i < 256 && cyc < 2000 && !aborted) begin
            @(negedge clk);
            cyc++;
            if (i == abort_fill) begin
                reset = 1'b1; s_valid = 1'b0; start = 1'b0;
                #1;
                chk_quiet("abort_fill");
                aborted = 1'b1;
            end else begin
                ph = ~ph;
                start   = v.start_mid && (i == 50);
                s_valid = v.toggle ? ph : 1'b1;
                s_data  = 12'(raw_data(v.pat, i));
                if (s_valid && s_ready) i++;
            end
        end
        if (!aborted && i < 256) chk("fill_timeout", i, 256);

        if (!aborted) begin
            @(negedge clk);
            s_valid = 1'b0; start = 1'b0;
            chk("loadp_pulse", int'({load_a_f, load_a_i, load_b_f, load_b_i}), int'(v.exp_load));
            chk("loadp_ready", int'(s_ready), 0);
            chk("loadp_din", int'(din), 0);
            for (int r = 0; r < 256 && !aborted; r++) begin
                @(negedge clk);
                start = v.start_mid && (r == 100);
                exp_w = stored_data(v.pat, exp_index(v.inv, r));
                chk($sformatf("din_w%0d", r), int'(din), exp_w);
                if (r == abort_drain) begin
                    reset = 1'b1; start = 1'b0;
                    #1;
                    chk_quiet("abort_drain");
                    aborted = 1'b1;
                end
            end
        end

        if (!aborted) begin
            @(negedge clk);
            start = 1'b0;
            chk("fin_done", int'(done), 1);
            chk("fin_din", int'(din), 0);
            chk("fin_busy", int'(busy), 1);
            @(negedge clk);
            chk("idle_busy", int'(busy), 0);
            chk("idle_done", int'(done), 0);
        end else begin
            @(negedge clk);
            reset = 1'b0;
            chk_quiet("post_reset");
        end

        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("load_cnt%0d", k), cnt_load[k] - base_load[k],
                (abort_fill >= 0) ? 0 : int'(v.exp_load[3-k]));
        end
        chk("done_cnt", cnt_done - base_done, (abort_fill < 0 && abort_drain < 0) ? 1 : 0);
    endtask

    initial begin
        vecs[0] = '{sel_b: 1'b0, inv: 1'b1, toggle: 1'b0, pat: 0, start_mid: 1'b0, exp_load: 4'b0100};
        vecs[1] = '{sel_b: 1'b1, inv: 1'b0, toggle: 1'b1, pat: 1, start_mid: 1'b0, exp_load: 4'b0010};
        vecs[2] = '{sel_b: 1'b0, inv: 1'b0, toggle: 1'b0, pat: 2, start_mid: 1'b1, exp_load: 4'b1000};
        vecs[3] = '{sel_b: 1'b1, inv: 1'b1, toggle: 1'b1, pat: 2, start_mid: 1'b1, exp_load: 4'b0001};

        repeat (3) @(negedge clk);
        chk_quiet("reset");
        reset = 1'b0;
        @(negedge clk);
        s_valid = 1'b1;
        @(negedge clk);
        chk("idle_ignores_valid", int'(s_ready), 0);
        s_valid = 1'b0;

        for (int k = 0; k < 4; k++) run_vec(vecs[k], -1, -1);
        run_vec(vecs[1], 100, -1);
        run_vec(vecs[0], -1, 50);
        run_vec(vecs[3], -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
